inst_cache_fetch: RTL and testbench

- Instruction-side responder to the program counter.
- Each cycle it takes the PC value and returns the 32-bit instruction from a direct-mapped cache.
- On a miss it drives InstCacheEn high, so the PC holds, while it refills the line from backing memory over a per-word req/ack handshake.
- Sits between the PC register and the instruction memory / bus bridge in the core.

---
 rtl/inst_cache_fetch_pkg.sv | 13 +
 rtl/inst_cache_array.sv | 44 ++++
 rtl/inst_cache_fetch.sv | 97 +++++++++
 tb/tb_inst_cache_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_fetch_pkg.sv
// Shared definitions for the instruction fetch cache: widths, the NOP filler and FSM states.
package inst_cache_fetch_pkg;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 16;
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = DATA_W - 2 - WORD_W - IDX_W;

  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {IDLE, REFILL} state_e;
endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped line storage: async-reset valid bits, unreset tag/data, combinational read.
module inst_cache_array #(
  parameter int DATA_W     = inst_cache_fetch_pkg::DATA_W,
  parameter int LINE_WORDS = inst_cache_fetch_pkg::LINE_WORDS,
  parameter int NUM_LINES  = inst_cache_fetch_pkg::NUM_LINES,
  localparam int WW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = DATA_W - 2 - WW - IW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     rd_idx_i,
  input  logic [WW-1:0]     rd_word_i,
  input  logic [TW-1:0]     rd_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [WW-1:0]     wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              tag_we_i,
  input  logic [TW-1:0]     wr_tag_i,
  input  logic              set_valid_i,
  input  logic              flush_i
);
  logic [NUM_LINES-1:0]                              valid_q;
  logic [NUM_LINES-1:0][TW-1:0]                      tag_q;
  logic [NUM_LINES-1:0][LINE_WORDS-1:0][DATA_W-1:0]  data_q;

  // Flush wins over a same-cycle validate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              valid_q <= '0;
    else if (flush_i)     valid_q <= '0;
    else if (set_valid_i) valid_q[wr_idx_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)  data_q[wr_idx_i][wr_word_i] <= wr_data_i;
    if (tag_we_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i][rd_word_i];
endmodule

// File: rtl/inst_cache_fetch.sv
// PC-side fetch responder: zero-latency hit path, stalls the PC and refills a line word-by-word on a miss.
module inst_cache_fetch #(
  parameter int DATA_W     = inst_cache_fetch_pkg::DATA_W,
  parameter int LINE_WORDS = inst_cache_fetch_pkg::LINE_WORDS,
  parameter int NUM_LINES  = inst_cache_fetch_pkg::NUM_LINES,
  localparam int WW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = DATA_W - 2 - WW - IW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PcAddr,
  input  logic              Flush,
  output logic [DATA_W-1:0] Inst,
  output logic              InstCacheEn,
  output logic              MemReq,
  output logic [DATA_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData
);
  import inst_cache_fetch_pkg::*;

  localparam logic [DATA_W-1:0] LINE_MASK = DATA_W'(LINE_WORDS*4 - 1);
  localparam logic [WW-1:0]     K_LAST    = WW'(LINE_WORDS - 1);

  state_e              state_q;
  logic [WW-1:0]       k_q;
  logic [DATA_W-1:0]   miss_base_q;
  logic                flush_pend_q;

  logic                hit;
  logic [DATA_W-1:0]   rd_data;
  logic                in_refill, wr_en, last_ack, flush_now;
  logic                unused_ok;

  assign in_refill = (state_q == REFILL);
  assign wr_en     = in_refill && MemAck;
  assign last_ack  = wr_en && (k_q == K_LAST);
  // A flush seen anywhere in the refill (including the final ack) suppresses validation.
  assign flush_now = Flush || flush_pend_q;
  assign unused_ok = &{1'b0, PcAddr[1:0]};

  inst_cache_array #(
    .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)
  ) u_array (
    .clk         (clk),
    .rst         (reset),
    .rd_idx_i    (PcAddr[2+WW +: IW]),
    .rd_word_i   (PcAddr[2 +: WW]),
    .rd_tag_i    (PcAddr[DATA_W-1 -: TW]),
    .hit_o       (hit),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_idx_i    (miss_base_q[2+WW +: IW]),
    .wr_word_i   (k_q),
    .wr_data_i   (MemData),
    .tag_we_i    (last_ack),
    .wr_tag_i    (miss_base_q[DATA_W-1 -: TW]),
    .set_valid_i (last_ack && !flush_now),
    .flush_i     ((!in_refill && Flush) || (last_ack && flush_now))
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      miss_base_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            miss_base_q <= PcAddr & ~LINE_MASK;
            k_q         <= '0;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (Flush) flush_pend_q <= 1'b1;
          if (MemAck) begin
            k_q <= k_q + 1'b1;
            if (k_q == K_LAST) begin
              state_q      <= IDLE;
              flush_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemReq      = in_refill;
  assign MemAddr     = in_refill ? miss_base_q + DATA_W'({k_q, 2'b00}) : '0;
  assign InstCacheEn = in_refill || !hit;
  assign Inst        = InstCacheEn ? DATA_W'(NOP_INST) : rd_data;
endmodule

// File: tb/tb_inst_cache_fetch.sv
// Directed bench for inst_cache_fetch with a variable-latency memory responder.
module tb_inst_cache_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PcAddr;
  logic        Flush;
  logic [31:0] Inst;
  logic        InstCacheEn;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;

  int          checks = 0;
  int          errors = 0;
  int          mem_delay = 1;
  int          wait_cnt = 0;
  int          st;
  logic [31:0] ackq[$];

  inst_cache_fetch dut (
    .clk(clk), .reset(reset), .PcAddr(PcAddr), .Flush(Flush), .Inst(Inst),
    .InstCacheEn(InstCacheEn), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData)
  );

  always #5 clk = ~clk;

  // Memory word pattern: line 0x40 returns 0xA0..0xA3.
  function automatic logic [31:0] md(input logic [31:0] a);
    logic [31:0] hi;
    hi = {4'h0, a[31:4] ^ 28'h4};
    return 32'hA0 + {30'd0, a[3:2]} + (hi << 8);
  endfunction

  // Acks each request after mem_delay waiting cycles.
  always @(posedge clk) begin
    #1;
    MemAck = 1'b0;
    if (MemReq) begin
      if (wait_cnt >= mem_delay) begin
        MemAck   = 1'b1;
        MemData  = md(MemAddr);
        ackq.push_back(MemAddr);
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present an address at a negedge and count the cycles it is stalled.
  task automatic access(input logic [31:0] a, output int stalls);
    PcAddr = a;
    stalls = 0;
    #1;
    while (InstCacheEn === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; PcAddr = 32'h40; Flush = 1'b0; MemAck = 1'b0; MemData = '0;
    repeat (2) @(negedge clk);
    chk("rst_en",   {31'd0, InstCacheEn}, 32'd1);
    chk("rst_req",  {31'd0, MemReq},      32'd0);
    chk("rst_addr", MemAddr,              32'h0);
    chk("rst_inst", Inst,                 32'h13);
    reset = 1'b0;

    // 1: cold miss, one wait cycle per word
    mem_delay = 1; ackq.delete();
    access(32'h40, st);
    chk("cold_stall", st, 9);
    chk("cold_inst",  Inst, 32'hA0);
    chk("cold_a0", ackq[0], 32'h40);
    chk("cold_a1", ackq[1], 32'h44);
    chk("cold_a2", ackq[2], 32'h48);
    chk("cold_a3", ackq[3], 32'h4C);

    // 2: hit
    @(negedge clk);
    access(32'h48, st);
    chk("hit_stall", st, 0);
    chk("hit_inst",  Inst, 32'hA2);
    chk("hit_req",   {31'd0, MemReq}, 32'd0);

    // 3: conflict miss on index 4
    mem_delay = 0; ackq.delete();
    @(negedge clk);
    access(32'h140, st);
    chk("conf_stall", st, 5);
    chk("conf_inst",  Inst, 32'h10A0);
    chk("conf_a0",    ackq[0], 32'h140);
    @(negedge clk);
    access(32'h40, st);
    chk("conf_back_stall", st, 5);
    chk("conf_back_inst",  Inst, 32'hA0);

    // 4: slow memory, PC wanders mid-refill
    mem_delay = 5; ackq.delete();
    @(negedge clk);
    PcAddr = 32'h200; st = 0; #1;
    while (InstCacheEn === 1'b1 && st < 400) begin
      if (st == 3) begin
        chk("slow_req",  {31'd0, MemReq}, 32'd1);
        chk("slow_addr", MemAddr, 32'h200);
        PcAddr = 32'h300;
      end
      if (st == 5) begin
        chk("slow_addr_pc", MemAddr, 32'h200);
        PcAddr = 32'h204;
      end
      st++;
      @(negedge clk); #1;
    end
    chk("slow_stall", st, 25);
    chk("slow_inst",  Inst, 32'h24A1);
    chk("slow_a0", ackq[0], 32'h200);
    chk("slow_a3", ackq[3], 32'h20C);

    // 5a: flush in IDLE, same-cycle lookup still hits
    mem_delay = 0;
    @(negedge clk);
    PcAddr = 32'h40; Flush = 1'b1; #1;
    chk("fl_same_en",   {31'd0, InstCacheEn}, 32'd0);
    chk("fl_same_inst", Inst, 32'hA0);
    @(negedge clk);
    Flush = 1'b0;
    access(32'h40, st);
    chk("fl_idle_stall", st, 5);

    // 5b: flush during refill of 0x80 -> line refilled twice
    mem_delay = 1; ackq.delete();
    @(negedge clk);
    PcAddr = 32'h80; st = 0; #1;
    while (InstCacheEn === 1'b1 && st < 400) begin
      if (st == 2) Flush = 1'b1;
      if (st == 3) Flush = 1'b0;
      st++;
      @(negedge clk); #1;
    end
    chk("fl_ref_stall", st, 18);
    chk("fl_ref_inst",  Inst, 32'hCA0);
    chk("fl_ref_a4",    ackq[4], 32'h80);
    @(negedge clk);
    access(32'h40, st);
    chk("fl_ref_other", st, 9);

    // 6: reset after two acks of a refill
    ackq.delete();
    @(negedge clk);
    PcAddr = 32'hC0; st = 0; #1;
    while (InstCacheEn === 1'b1 && st < 5) begin
      st++;
      @(negedge clk); #1;
    end
    chk("mid_acks", ackq.size(), 2);
    reset = 1'b1; #1;
    chk("mid_req",  {31'd0, MemReq}, 32'd0);
    chk("mid_addr", MemAddr, 32'h0);
    chk("mid_en",   {31'd0, InstCacheEn}, 32'd1);
    chk("mid_inst", Inst, 32'h13);
    @(negedge clk);
    reset = 1'b0; ackq.delete();
    access(32'h40, st);
    chk("post_stall", st, 9);
    chk("post_a0",    ackq[0], 32'h40);
    chk("post_inst",  Inst, 32'hA0);
    @(negedge clk);
    access(32'hC0, st);
    chk("post_c0_stall", st, 9);
    chk("post_c0_inst",  Inst, 32'h8A0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
